// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger -- ranging front-end for the bay-occupancy ultrasonic sensor.
// Issues periodic trigger pulses, times the echo pulse, converts the width to
// centimetres and drives a debounced, hysteretic vehicle-present flag.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   enable       high: ranging cycles run
//   echo         raw sensor echo (asynchronous)
//   trig         sensor trigger pulse
//   distance_cm  last measured distance, all ones on timeout / saturation
//   dist_valid   one-cycle pulse when distance_cm updates
//   timeout      one-cycle pulse when a measurement times out
//   detected     debounced vehicle-present flag
//   busy         high whenever the ranging state machine is not idle
module ultrasonic_ranger #(
   parameter int unsigned TRIG_CYCLES         = 500,
   parameter int unsigned PERIOD_CYCLES       = 3000000,
   parameter int unsigned ECHO_TIMEOUT_CYCLES = 1500000,
   parameter int unsigned CYCLES_PER_CM       = 2900,
   parameter int unsigned DIST_W              = 9,
   parameter int unsigned NEAR_CM             = 30,
   parameter int unsigned FAR_CM              = 40,
   parameter int unsigned CONFIRM             = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              echo,
   output logic              trig,
   output logic [DIST_W-1:0] distance_cm,
   output logic              dist_valid,
   output logic              timeout,
   output logic              detected,
   output logic              busy
);

   // period_cnt must not wrap even when a full wait plus a full echo overrun the period
   localparam int unsigned PW = $clog2(PERIOD_CYCLES + TRIG_CYCLES + 2*ECHO_TIMEOUT_CYCLES + 4);
   localparam int unsigned TW = $clog2(ECHO_TIMEOUT_CYCLES + 1);
   localparam int unsigned HW = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

   localparam logic [PW-1:0] TRIG_LAST   = PW'(TRIG_CYCLES - 1);
   localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST    = TW'(ECHO_TIMEOUT_CYCLES - 1);
   localparam logic [HW-1:0] HI_LAST     = HW'(CYCLES_PER_CM - 1);
   localparam logic [3:0]    CONF        = 4'(CONFIRM);

   typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_HOLDOFF} state_t;

   state_t            state, state_d;
   logic              echo_meta, echo_s, echo_prev;
   logic [PW-1:0]     period_cnt, period_cnt_d;
   logic [TW-1:0]     tmo_cnt, tmo_cnt_d;
   logic [HW-1:0]     hi_cnt, hi_cnt_d;
   logic [DIST_W-1:0] cm_cnt, cm_cnt_d;
   logic [3:0]        near_cnt, near_cnt_d, far_cnt, far_cnt_d;
   logic [3:0]        near_inc, far_inc;
   logic [DIST_W-1:0] distance_d;
   logic              trig_d, dist_valid_d, timeout_d, detected_d;
   logic              rise, result, is_far, is_near;

   assign rise = echo_s & ~echo_prev;
   assign busy = (state != S_IDLE);

   always_comb begin
      state_d      = state;
      period_cnt_d = period_cnt + 1'b1;
      tmo_cnt_d    = tmo_cnt;
      hi_cnt_d     = hi_cnt;
      cm_cnt_d     = cm_cnt;
      near_cnt_d   = near_cnt;
      far_cnt_d    = far_cnt;
      distance_d   = distance_cm;
      trig_d       = trig;
      dist_valid_d = 1'b0;
      timeout_d    = 1'b0;
      detected_d   = detected;
      result       = 1'b0;
      is_far       = 1'b0;
      is_near      = 1'b0;
      near_inc     = (near_cnt == CONF) ? CONF : near_cnt + 4'd1;
      far_inc      = (far_cnt == CONF) ? CONF : far_cnt + 4'd1;

      case (state)
         S_IDLE: begin
            period_cnt_d = '0;
            if (enable) begin
               state_d = S_TRIG;
               trig_d  = 1'b1;
            end
         end
         S_TRIG: begin
            if (!enable) begin
               state_d = S_IDLE;
               trig_d  = 1'b0;
            end else if (period_cnt == TRIG_LAST) begin
               state_d   = S_WAIT_RISE;
               trig_d    = 1'b0;
               tmo_cnt_d = '0;
            end
         end
         S_WAIT_RISE: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (rise) begin
               // The cycle that reveals the rise is already the first high
               // cycle, so the cleared counters take that cycle's increment.
               state_d   = S_MEASURE;
               tmo_cnt_d = TW'(1);
               hi_cnt_d  = (HI_LAST == '0) ? '0 : HW'(1);
               cm_cnt_d  = (HI_LAST == '0) ? DIST_W'(1) : '0;
            end else if (tmo_cnt >= TMO_LAST) begin
               state_d = S_HOLDOFF;
               result  = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt + 1'b1;
            end
         end
         S_MEASURE: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (!echo_s) begin
               state_d      = S_HOLDOFF;
               distance_d   = cm_cnt;
               dist_valid_d = 1'b1;
               result       = 1'b1;
            end else if (tmo_cnt >= TMO_LAST) begin
               state_d = S_HOLDOFF;
               result  = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt + 1'b1;
               if (hi_cnt == HI_LAST) begin
                  hi_cnt_d = '0;
                  if (cm_cnt != '1) cm_cnt_d = cm_cnt + 1'b1;
               end else begin
                  hi_cnt_d = hi_cnt + 1'b1;
               end
            end
         end
         S_HOLDOFF: begin
            if (period_cnt >= PERIOD_LAST) begin
               if (enable) begin
                  state_d      = S_TRIG;
                  trig_d       = 1'b1;
                  period_cnt_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A result without a loaded distance is a timeout.
      if (result && !dist_valid_d) begin
         timeout_d    = 1'b1;
         dist_valid_d = 1'b1;
         distance_d   = '1;
      end

      if (result) begin
         is_far  = timeout_d || (32'(distance_d) >= FAR_CM);
         is_near = !is_far && (32'(distance_d) <= NEAR_CM);
         if (is_far) begin
            far_cnt_d  = far_inc;
            near_cnt_d = '0;
            if (far_inc == CONF) detected_d = 1'b0;
         end else if (is_near) begin
            near_cnt_d = near_inc;
            far_cnt_d  = '0;
            if (near_inc == CONF) detected_d = 1'b1;
         end else begin
            near_cnt_d = '0;
            far_cnt_d  = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         echo_meta   <= 1'b0;
         echo_s      <= 1'b0;
         echo_prev   <= 1'b0;
         period_cnt  <= '0;
         tmo_cnt     <= '0;
         hi_cnt      <= '0;
         cm_cnt      <= '0;
         near_cnt    <= '0;
         far_cnt     <= '0;
         trig        <= 1'b0;
         distance_cm <= '1;
         dist_valid  <= 1'b0;
         timeout     <= 1'b0;
         detected    <= 1'b0;
      end else begin
         echo_meta   <= echo;
         echo_s      <= echo_meta;
         echo_prev   <= echo_s;
         state       <= state_d;
         period_cnt  <= period_cnt_d;
         tmo_cnt     <= tmo_cnt_d;
         hi_cnt      <= hi_cnt_d;
         cm_cnt      <= cm_cnt_d;
         near_cnt    <= near_cnt_d;
         far_cnt     <= far_cnt_d;
         trig        <= trig_d;
         distance_cm <= distance_d;
         dist_valid  <= dist_valid_d;
         timeout     <= timeout_d;
         detected    <= detected_d;
      end
   end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with small timing parameters.
module tb_ultrasonic_ranger;

   logic       clk = 1'b0;
   logic       reset, enable, echo;
   logic       trig, dist_valid, timeout, detected, busy;
   logic [8:0] distance_cm;

   int n_err = 0;
   int n_checks = 0;
   int cyc = 0;
   int last_rise = 0;
   bit have_rise = 0;
   int n_ev;

   ultrasonic_ranger #(
      .TRIG_CYCLES(4),
      .PERIOD_CYCLES(200),
      .ECHO_TIMEOUT_CYCLES(100),
      .CYCLES_PER_CM(2),
      .DIST_W(9),
      .NEAR_CM(10),
      .FAR_CM(15),
      .CONFIRM(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .echo(echo),
      .trig(trig),
      .distance_cm(distance_cm),
      .dist_valid(dist_valid),
      .timeout(timeout),
      .detected(detected),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for the trig rise; check busy stayed high and the period.
   task automatic wait_rise(input string tag);
      int n = 0;
      bit busy_ok = 1;
      while (trig !== 1'b1 && n < 400) begin
         tick();
         n++;
         if (busy !== 1'b1) busy_ok = 0;
      end
      check({tag, "_trig_seen"}, trig, 1);
      if (have_rise) begin
         check({tag, "_busy"}, busy_ok, 1);
         check({tag, "_period"}, cyc - last_rise, 200);
      end
      have_rise = 1;
      last_rise = cyc;
   endtask

   // Trig observed high after the rise edge; must be high 4 cycles exactly.
   task automatic trig_phase(input string tag);
      repeat (3) tick();
      check({tag, "_trig_hi"}, trig, 1);
      tick();
      check({tag, "_trig_lo"}, trig, 0);
   endtask

   task automatic echo_period(input int w, input int exp_d, input logic exp_det, input string tag);
      wait_rise(tag);
      trig_phase(tag);
      echo = 1'b1;
      repeat (w) tick();
      echo = 1'b0;
      tick();
      tick();
      check({tag, "_dv_early"}, dist_valid, 0);
      tick();
      check({tag, "_dv"}, dist_valid, 1);
      check({tag, "_dist"}, distance_cm, exp_d);
      check({tag, "_tmo"}, timeout, 0);
      check({tag, "_det"}, detected, exp_det);
      tick();
      check({tag, "_dv_once"}, dist_valid, 0);
   endtask

   task automatic timeout_period(input logic exp_det, input string tag);
      wait_rise(tag);
      trig_phase(tag);
      repeat (99) tick();
      check({tag, "_tmo_early"}, timeout, 0);
      tick();
      check({tag, "_tmo"}, timeout, 1);
      check({tag, "_dv"}, dist_valid, 1);
      check({tag, "_dist"}, distance_cm, 511);
      check({tag, "_det"}, detected, exp_det);
      tick();
      check({tag, "_tmo_once"}, timeout, 0);
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b0;
      echo = 1'b0;
      repeat (3) tick();
      check("rst_trig", trig, 0);
      check("rst_dist", distance_cm, 511);
      check("rst_dv", dist_valid, 0);
      check("rst_tmo", timeout, 0);
      check("rst_det", detected, 0);
      check("rst_busy", busy, 0);

      reset = 1'b0;
      enable = 1'b1;

      // near at the threshold, confirmed on the third result
      echo_period(20, 10, 1'b0, "p1");
      echo_period(20, 10, 1'b0, "p2");
      echo_period(20, 10, 1'b1, "p3");

      // far, far, between (clears far_cnt), then three far
      echo_period(40, 20, 1'b1, "h1");
      echo_period(40, 20, 1'b1, "h2");
      echo_period(24, 12, 1'b1, "h3");
      echo_period(40, 20, 1'b1, "h4");
      echo_period(40, 20, 1'b1, "h5");
      echo_period(40, 20, 1'b0, "h6");

      // re-detect, then three echo-less timeouts clear it
      echo_period(20, 10, 1'b0, "n1");
      echo_period(20, 10, 1'b0, "n2");
      echo_period(20, 10, 1'b1, "n3");
      timeout_period(1'b1, "w1");
      timeout_period(1'b1, "w2");
      timeout_period(1'b0, "w3");

      // echo stuck high 150 cycles: timeout after 100 high cycles
      wait_rise("t5");
      trig_phase("t5");
      echo = 1'b1;
      repeat (101) tick();
      check("t5_tmo_early", timeout, 0);
      tick();
      check("t5_tmo", timeout, 1);
      check("t5_dv", dist_valid, 1);
      check("t5_dist", distance_cm, 511);
      repeat (48) tick();
      echo = 1'b0;
      n_ev = 0;
      for (int i = 0; i < 400 && trig !== 1'b1; i++) begin
         tick();
         if (dist_valid === 1'b1 || timeout === 1'b1) n_ev++;
      end
      check("t5_holdoff_quiet", n_ev, 0);
      wait_rise("t5_next");
      trig_phase("t5_next");
      echo = 1'b1;
      repeat (20) tick();
      echo = 1'b0;
      tick();
      tick();
      tick();
      check("t5_next_dist", distance_cm, 10);

      // build detected=1 again, then drop enable mid-MEASURE
      echo_period(20, 10, 1'b0, "m1");
      echo_period(20, 10, 1'b1, "m2");
      wait_rise("t6a");
      trig_phase("t6a");
      echo = 1'b1;
      repeat (10) tick();
      enable = 1'b0;
      tick();
      check("t6a_trig", trig, 0);
      check("t6a_busy", busy, 0);
      check("t6a_dv", dist_valid, 0);
      check("t6a_det", detected, 1);
      check("t6a_dist", distance_cm, 10);
      repeat (5) tick();
      echo = 1'b0;
      n_ev = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (dist_valid === 1'b1 || timeout === 1'b1 || busy === 1'b1) n_ev++;
      end
      check("t6a_quiet", n_ev, 0);
      check("t6a_det_hold", detected, 1);

      // reset mid-MEASURE
      enable = 1'b1;
      have_rise = 0;
      wait_rise("t6b");
      trig_phase("t6b");
      echo = 1'b1;
      repeat (10) tick();
      reset = 1'b1;
      echo = 1'b0;
      tick();
      check("t6b_trig", trig, 0);
      check("t6b_busy", busy, 0);
      check("t6b_dv", dist_valid, 0);
      check("t6b_det", detected, 0);
      check("t6b_dist", distance_cm, 511);
      reset = 1'b0;
      have_rise = 0;
      timeout_period(1'b0, "t6c");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
